// File: rtl/wb_arbiter_rr.sv
// Round-robin N-master Wishbone B3 arbiter for a single shared slave.
// A slave-response watchdog ends hung cycles with a bus error to the owning master.
module wb_arbiter_rr #(
  parameter int unsigned num_masters = 2,
  parameter int unsigned aw          = 32,
  parameter int unsigned dw          = 32,
  parameter int unsigned timeout     = 255
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  // master side
  input  logic [num_masters*aw-1:0]       wbm_adr_i,
  input  logic [num_masters*dw-1:0]       wbm_dat_i,
  input  logic [num_masters*(dw/8)-1:0]   wbm_sel_i,
  input  logic [num_masters-1:0]          wbm_we_i,
  input  logic [num_masters-1:0]          wbm_cyc_i,
  input  logic [num_masters-1:0]          wbm_stb_i,
  input  logic [num_masters*3-1:0]        wbm_cti_i,
  input  logic [num_masters*2-1:0]        wbm_bte_i,
  output logic [num_masters*dw-1:0]       wbm_dat_o,
  output logic [num_masters-1:0]          wbm_ack_o,
  output logic [num_masters-1:0]          wbm_err_o,
  output logic [num_masters-1:0]          wbm_rty_o,
  // slave side
  output logic [aw-1:0]                   wbs_adr_o,
  output logic [dw-1:0]                   wbs_dat_o,
  output logic [dw/8-1:0]                 wbs_sel_o,
  output logic                            wbs_we_o,
  output logic                            wbs_cyc_o,
  output logic                            wbs_stb_o,
  output logic [2:0]                      wbs_cti_o,
  output logic [1:0]                      wbs_bte_o,
  input  logic [dw-1:0]                   wbs_dat_i,
  input  logic                            wbs_ack_i,
  input  logic                            wbs_err_i,
  input  logic                            wbs_rty_i,
  // status
  output logic [num_masters-1:0]          grant_o,
  output logic                            timeout_o
);

  localparam int unsigned GW = (num_masters > 1) ? $clog2(num_masters) : 1;
  localparam int unsigned SW = dw / 8;

  typedef enum logic [1:0] {StIdle, StBusy, StTerr} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] pick;
  logic          any_req;
  logic          cyc_g, stb_g;
  logic          resp;
  logic          expire;
  int unsigned   gidx;

  assign any_req = |wbm_cyc_i;
  assign gidx    = 32'(gnt_q);
  assign cyc_g   = wbm_cyc_i[gidx];
  assign stb_g   = wbm_stb_i[gidx];
  assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // First requester scanning upward from the one after the last winner.
  always_comb begin : rr_pick
    logic        found;
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= num_masters; k++) begin
      idx = (32'(last_q) + k) % num_masters;
      if (!found && wbm_cyc_i[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // Request path: the granted master's slice drives the slave.
  assign wbs_adr_o = wbm_adr_i[gidx*aw +: aw];
  assign wbs_dat_o = wbm_dat_i[gidx*dw +: dw];
  assign wbs_sel_o = wbm_sel_i[gidx*SW +: SW];
  assign wbs_we_o  = wbm_we_i[gidx];
  assign wbs_cti_o = wbm_cti_i[gidx*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[gidx*2 +: 2];
  assign wbs_cyc_o = (state_q == StBusy) & cyc_g;
  assign wbs_stb_o = (state_q == StBusy) & cyc_g & stb_g;

  assign wbm_dat_o = {num_masters{wbs_dat_i}};
  assign timeout_o = (state_q == StTerr);

  always_comb begin : resp_route
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    grant_o   = '0;
    if (state_q != StIdle) begin
      grant_o[gidx] = 1'b1;
    end
    if (state_q == StBusy) begin
      wbm_ack_o[gidx] = wbs_ack_i & wbs_stb_o;
      wbm_err_o[gidx] = wbs_err_i & wbs_stb_o;
      wbm_rty_o[gidx] = wbs_rty_i & wbs_stb_o;
    end else if (state_q == StTerr) begin
      // Late slave responses are swallowed here.
      wbm_err_o[gidx] = 1'b1;
    end
  end

  if (timeout != 0) begin : g_wdog
    localparam int unsigned WW = $clog2(timeout + 1);
    logic [WW-1:0] wdc_q, wdc_d;

    always_comb begin
      wdc_d = (!wbs_stb_o || resp) ? '0 : wdc_q + 1'b1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        wdc_q <= '0;
      end else begin
        wdc_q <= wdc_d;
      end
    end

    // A response in the expiry cycle wins over the watchdog.
    assign expire = wbs_stb_o && !resp && (wdc_q == WW'(timeout - 1));
  end else begin : g_no_wdog
    assign expire = 1'b0;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d   = pick;
          last_d  = pick;
          state_d = StBusy;
        end
      end
      StBusy, StTerr: begin
        if (expire) begin
          state_d = StTerr;
        end else if (cyc_g) begin
          state_d = StBusy;
        end else if (any_req) begin
          gnt_d   = pick;
          last_d  = pick;
          state_d = StBusy;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= GW'(num_masters - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: vector table for arbitration/routing,
// hand sequences for bursts, watchdog and asynchronous reset.
module tb_wb_arbiter_rr;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NM*AW-1:0]     adr;
  logic [NM*DW-1:0]     mdat;
  logic [NM*DW/8-1:0]   sel;
  logic [NM-1:0]        we;
  logic [NM-1:0]        cyc;
  logic [NM-1:0]        stb;
  logic [NM*3-1:0]      cti;
  logic [NM*2-1:0]      bte;
  logic [NM*DW-1:0]     wbm_dat_o;
  logic [NM-1:0]        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]        wbs_adr_o;
  logic [DW-1:0]        wbs_dat_o;
  logic [DW/8-1:0]      wbs_sel_o;
  logic                 wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]           wbs_cti_o;
  logic [1:0]           wbs_bte_o;
  logic [DW-1:0]        sdat;
  logic                 sack, serr, srty;
  logic [NM-1:0]        grant_o;
  logic                 timeout_o;

  int n_chk  = 0;
  int n_pass = 0;

  wb_arbiter_rr #(
    .num_masters(NM),
    .aw         (AW),
    .dw         (DW),
    .timeout    (TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbm_adr_i(adr),
    .wbm_dat_i(mdat),
    .wbm_sel_i(sel),
    .wbm_we_i (we),
    .wbm_cyc_i(cyc),
    .wbm_stb_i(stb),
    .wbm_cti_i(cti),
    .wbm_bte_i(bte),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(sdat),
    .wbs_ack_i(sack),
    .wbs_err_i(serr),
    .wbs_rty_i(srty),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] cyc;
    logic [2:0] stb;
    logic       sack;
    logic       srty;
    logic [2:0] e_grant;
    logic       e_scyc;
    logic [2:0] e_ack;
    logic [2:0] e_rty;
  } vec_t;

  vec_t tbl[$];
  int   rr_len;
  int   ack_cnt[NM];

  task automatic add(input logic r, input logic [2:0] c, input logic [2:0] s, input logic a,
                     input logic y, input logic [2:0] eg, input logic ec, input logic [2:0] ea,
                     input logic [2:0] ey);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.sack = a; v.srty = y;
    v.e_grant = eg; v.e_scyc = ec; v.e_ack = ea; v.e_rty = ey;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic step(input logic [2:0] c, input logic [2:0] s, input logic a);
    @(negedge clk);
    cyc = c; stb = s; sack = a;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cyc = '0; stb = '0; sack = 1'b0; srty = 1'b0; serr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(NM); i++) begin
      adr[i*AW +: AW]   = AW'(16'h1000 + i);
      mdat[i*DW +: DW]  = DW'(32'hD000_0000 + i);
      sel[i*4 +: 4]     = 4'hF;
      ack_cnt[i]        = 0;
    end
    we = '0; cyc = '0; stb = '0; cti = '0; bte = '0;
    sdat = 32'hCAFE_0123; sack = 1'b0; serr = 1'b0; srty = 1'b0;

    // Round robin, all three continuously requesting single-beat cycles.
    add(1, 3'b000, 3'b000, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b111, 3'b111, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b111, 3'b111, 1, 0, 3'b001, 1, 3'b001, 3'b000);
    add(0, 3'b110, 3'b110, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add(0, 3'b111, 3'b111, 1, 0, 3'b010, 1, 3'b010, 3'b000);
    add(0, 3'b101, 3'b101, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add(0, 3'b111, 3'b111, 1, 0, 3'b100, 1, 3'b100, 3'b000);
    add(0, 3'b011, 3'b011, 0, 0, 3'b100, 0, 3'b000, 3'b000);
    add(0, 3'b111, 3'b111, 1, 0, 3'b001, 1, 3'b001, 3'b000);
    add(0, 3'b110, 3'b110, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add(0, 3'b111, 3'b111, 1, 0, 3'b010, 1, 3'b010, 3'b000);
    add(0, 3'b101, 3'b101, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add(0, 3'b111, 3'b111, 1, 0, 3'b100, 1, 3'b100, 3'b000);
    add(0, 3'b011, 3'b011, 0, 0, 3'b100, 0, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    rr_len = tbl.size();
    // Two masters start together; handover; stb gating; rty routing.
    add(1, 3'b000, 3'b000, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b011, 3'b011, 0, 0, 3'b000, 0, 3'b000, 3'b000);
    add(0, 3'b011, 3'b011, 1, 0, 3'b001, 1, 3'b001, 3'b000);
    add(0, 3'b010, 3'b010, 0, 0, 3'b001, 0, 3'b000, 3'b000);
    add(0, 3'b010, 3'b000, 1, 0, 3'b010, 1, 3'b000, 3'b000);
    add(0, 3'b010, 3'b010, 0, 1, 3'b010, 1, 3'b000, 3'b010);
    add(0, 3'b010, 3'b010, 1, 0, 3'b010, 1, 3'b010, 3'b000);
    add(0, 3'b000, 3'b000, 0, 0, 3'b010, 0, 3'b000, 3'b000);
    add(0, 3'b000, 3'b000, 0, 0, 3'b000, 0, 3'b000, 3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; cyc = tbl[i].cyc; stb = tbl[i].stb;
      sack = tbl[i].sack; srty = tbl[i].srty;
      #1;
      chk($sformatf("v%0d grant", i), 32'(grant_o), 32'(tbl[i].e_grant));
      chk($sformatf("v%0d wbs_cyc", i), 32'(wbs_cyc_o), 32'(tbl[i].e_scyc));
      chk($sformatf("v%0d ack", i), 32'(wbm_ack_o), 32'(tbl[i].e_ack));
      chk($sformatf("v%0d rty", i), 32'(wbm_rty_o), 32'(tbl[i].e_rty));
      for (int m = 0; m < int'(NM); m++) begin
        if (tbl[i].e_grant[m] && tbl[i].e_scyc)
          chk($sformatf("v%0d adr", i), 32'(wbs_adr_o), 32'h1000 + m);
        if (i < rr_len && wbm_ack_o[m]) ack_cnt[m]++;
      end
    end
    for (int m = 0; m < int'(NM); m++)
      chk($sformatf("rr share m%0d", m), 32'(ack_cnt[m]), 32'd2);
    chk("dat broadcast", wbm_dat_o[2*DW +: DW], 32'hCAFE_0123);

    // Four-beat burst by master 1 while master 0 waits.
    do_reset();
    cti[3 +: 3] = 3'b010;
    step(3'b010, 3'b010, 1'b0);
    for (int b = 0; b < 4; b++) begin
      cti[3 +: 3] = (b == 3) ? 3'b111 : 3'b010;
      step(3'b011, 3'b011, 1'b1);
      chk($sformatf("burst b%0d grant", b), 32'(grant_o), 32'b010);
      chk($sformatf("burst b%0d ack", b), 32'(wbm_ack_o), 32'b010);
      chk($sformatf("burst b%0d cti", b), 32'(wbs_cti_o), (b == 3) ? 32'b111 : 32'b010);
    end
    step(3'b001, 3'b001, 1'b0);
    chk("burst release grant", 32'(grant_o), 32'b010);
    step(3'b001, 3'b001, 1'b0);
    chk("burst handover grant", 32'(grant_o), 32'b001);
    chk("burst handover cyc", 32'(wbs_cyc_o), 32'd1);
    cti = '0;

    // Slave never answers: error pulse in cycle TO+1 after stb.
    do_reset();
    step(3'b001, 3'b001, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      step(3'b001, 3'b001, 1'b0);
      if (n == int'(TO) + 1) begin
        chk("wd err", 32'(wbm_err_o), 32'b001);
        chk("wd timeout_o", 32'(timeout_o), 32'd1);
        chk("wd stb low", 32'(wbs_stb_o), 32'd0);
        chk("wd cyc low", 32'(wbs_cyc_o), 32'd0);
        chk("wd ack low", 32'(wbm_ack_o), 32'd0);
      end else begin
        chk($sformatf("wd quiet c%0d", n), {timeout_o, wbm_err_o, wbs_stb_o}, 32'b0_000_1);
      end
    end
    step(3'b000, 3'b000, 1'b0);

    // Ack exactly in the last allowed cycle wins and restarts the count.
    do_reset();
    step(3'b001, 3'b001, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      step(3'b001, 3'b001, n == int'(TO));
      if (n == int'(TO)) begin
        chk("late ack", 32'(wbm_ack_o), 32'b001);
        chk("late ack no err", {timeout_o, wbm_err_o}, 32'd0);
      end else begin
        chk($sformatf("ack8 quiet c%0d", n), {timeout_o, wbm_err_o, wbs_stb_o}, 32'b0_000_1);
      end
    end
    step(3'b000, 3'b000, 1'b0);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    cti[0 +: 3] = 3'b010;
    step(3'b001, 3'b001, 1'b0);
    step(3'b001, 3'b001, 1'b1);
    chk("pre-reset ack", 32'(wbm_ack_o), 32'b001);
    @(negedge clk);
    cyc = 3'b011; stb = 3'b011; sack = 1'b1; rst = 1'b1;
    #1;
    chk("arst cyc", 32'(wbs_cyc_o), 32'd0);
    chk("arst grant", 32'(grant_o), 32'd0);
    chk("arst ack", 32'(wbm_ack_o), 32'd0);
    @(negedge clk);
    rst = 1'b0; sack = 1'b0;
    #1;
    chk("arst idle", 32'(grant_o), 32'd0);
    step(3'b011, 3'b011, 1'b0);
    chk("arst first grant", 32'(grant_o), 32'b001);
    step(3'b000, 3'b000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
